// File: rtl/encoder_stage_sequencer.sv
// encoder_stage_sequencer
//   Job-level controller for the matrix-encoder pipeline. Runs NUM_STAGES
//   function units one after another over the line buffer, ping-ponging the
//   read/write banks between stages and issuing each unit's clear/start
//   handshake.
//
//   Optional feature macro: SEQ_BYPASS_EN
//     defined   -> adds stage_mask input; a 1 skips that stage (1 cycle, no
//                  clr, no start, no bank toggle). Mask is sampled at accept.
//     undefined -> every stage always runs.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   job_valid    host requests a job
//   job_ready    sequencer can accept a job (IDLE)
//   job_done     1-cycle pulse when the job finishes
//   res_bank     bank holding the result, valid from job_done to next accept
//   busy         job in progress (CLEAR through FINISH)
//   stage_idx    index of the current stage
//   stage_clr    one-hot 1-cycle clear pulse to the current unit
//   stage_start  one-hot level start to the current unit
//   stage_done   unit done flags; only a rising edge advances the sequence
//   stage_mask   (SEQ_BYPASS_EN only) per-stage skip mask
//   rd_bank      bank the current stage reads; it writes ~rd_bank
//   job_count    completed jobs, wraps 255 -> 0
//   error        sticky stage timeout flag
//   err_stage    stage that timed out
//   err_clr      clears error and returns to IDLE
//
// State  | meaning
// IDLE   | waiting for a job, job_ready=1
// CLEAR  | 1-cycle clear pulse to current unit, timer loaded
// START  | start held, waiting for a fresh done rise or timeout
// SWAP   | 1 cycle, toggles rd_bank (unless skipped), selects next stage
// FINISH | 1 cycle, job_done pulse, result bank published
// ERR    | stage timed out, waiting for err_clr

module encoder_stage_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int TIMEOUT    = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    output logic                  job_done,
    output logic                  res_bank,
    output logic                  busy,
    output logic [1:0]            stage_idx,
    output logic [NUM_STAGES-1:0] stage_clr,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
`ifdef SEQ_BYPASS_EN
    input  logic [NUM_STAGES-1:0] stage_mask,
`endif
    output logic                  rd_bank,
    output logic [7:0]            job_count,
    output logic                  error,
    output logic [1:0]            err_stage,
    input  logic                  err_clr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        START  = 3'd2,
        SWAP   = 3'd3,
        FINISH = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [1:0]            LAST_IDX   = 2'(NUM_STAGES - 1);
    localparam logic [11:0]           TIMER_LOAD = 12'(TIMEOUT - 1);
    localparam logic [NUM_STAGES-1:0] ONE        = NUM_STAGES'(1);

    state_t                state;
    logic [11:0]           timer_rem;
    logic [NUM_STAGES-1:0] done_prev;
    logic [NUM_STAGES-1:0] mask_in;
    logic [NUM_STAGES-1:0] mask_r;
    logic                  skip;

    logic [1:0]            nxt_idx;
    logic [NUM_STAGES-1:0] cur_sel;
    logic [NUM_STAGES-1:0] nxt_sel;
    logic                  done_hit;
    logic                  nxt_skip;

`ifdef SEQ_BYPASS_EN
    assign mask_in = stage_mask;
`else
    assign mask_in = '0;
`endif

    assign nxt_idx  = stage_idx + 2'd1;
    assign cur_sel  = ONE << stage_idx;
    assign nxt_sel  = ONE << nxt_idx;
    // Only a 0->1 transition of the current unit's flag counts; a flag that
    // was already high when START began is ignored.
    assign done_hit = |(stage_done & ~done_prev & cur_sel);
    assign nxt_skip = |(mask_r & nxt_sel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            timer_rem   <= '0;
            done_prev   <= '0;
            mask_r      <= '0;
            skip        <= 1'b0;
            job_ready   <= 1'b1;
            job_done    <= 1'b0;
            res_bank    <= 1'b0;
            busy        <= 1'b0;
            stage_idx   <= '0;
            stage_clr   <= '0;
            stage_start <= '0;
            rd_bank     <= 1'b0;
            job_count   <= '0;
            error       <= 1'b0;
            err_stage   <= '0;
        end else begin
            done_prev <= stage_done;
            job_done  <= 1'b0;
            stage_clr <= '0;

            case (state)
                IDLE: begin
                    if (job_valid) begin
                        stage_idx <= '0;
                        rd_bank   <= 1'b0;
                        mask_r    <= mask_in;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (mask_in[0]) begin
                            state <= SWAP;
                            skip  <= 1'b1;
                        end else begin
                            state     <= CLEAR;
                            skip      <= 1'b0;
                            stage_clr <= ONE;
                        end
                    end
                end

                CLEAR: begin
                    state       <= START;
                    timer_rem   <= TIMER_LOAD;
                    stage_start <= cur_sel;
                end

                START: begin
                    // Edge has priority over a timeout in the same cycle.
                    if (done_hit) begin
                        state       <= SWAP;
                        skip        <= 1'b0;
                        stage_start <= '0;
                    end else if (timer_rem == 12'd0) begin
                        state       <= ERR;
                        stage_start <= '0;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                        err_stage   <= stage_idx;
                    end else begin
                        timer_rem <= timer_rem - 12'd1;
                    end
                end

                SWAP: begin
                    if (!skip) begin
                        rd_bank <= ~rd_bank;
                    end
                    if (stage_idx == LAST_IDX) begin
                        state     <= FINISH;
                        job_done  <= 1'b1;
                        res_bank  <= skip ? rd_bank : ~rd_bank;
                        job_count <= job_count + 8'd1;
                    end else begin
                        stage_idx <= nxt_idx;
                        if (nxt_skip) begin
                            state <= SWAP;
                            skip  <= 1'b1;
                        end else begin
                            state     <= CLEAR;
                            skip      <= 1'b0;
                            stage_clr <= nxt_sel;
                        end
                    end
                end

                FINISH: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    job_ready <= 1'b1;
                end

                ERR: begin
                    if (err_clr) begin
                        state     <= IDLE;
                        error     <= 1'b0;
                        err_stage <= '0;
                        job_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    job_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_stage_sequencer.sv
// Testbench for encoder_stage_sequencer: cycle-based driver with a simple
// unit model (done rises after a programmable number of start cycles) and a
// job-level reference model (latency, clear order, bank per stage, result).
module tb_encoder_stage_sequencer;

    localparam int N  = 3;
    localparam int TO = 4095;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic         job_done;
    logic         res_bank;
    logic         busy;
    logic [1:0]   stage_idx;
    logic [N-1:0] stage_clr;
    logic [N-1:0] stage_start;
    logic [N-1:0] stage_done;
    logic [N-1:0] mask_drv;
    logic         rd_bank;
    logic [7:0]   job_count;
    logic         error;
    logic [1:0]   err_stage;
    logic         err_clr;

    always #5 clk = ~clk;

    encoder_stage_sequencer #(.NUM_STAGES(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_done    (job_done),
        .res_bank    (res_bank),
        .busy        (busy),
        .stage_idx   (stage_idx),
        .stage_clr   (stage_clr),
        .stage_start (stage_start),
        .stage_done  (stage_done),
`ifdef SEQ_BYPASS_EN
        .stage_mask  (mask_drv),
`endif
        .rd_bank     (rd_bank),
        .job_count   (job_count),
        .error       (error),
        .err_stage   (err_stage),
        .err_clr     (err_clr)
    );

    int          compared = 0;
    int          mismatched = 0;
    int          cyc, done_cnt, done_cyc, first_clr_cyc, onehot_bad, exp_cnt;
    int          clr_code, bank_code;
    logic        res_obs;
    logic [7:0]  cnt_obs;
    int          dly[N];
    int          scnt[N];
    bit          unit_auto;

    // ---------------- reference model ----------------
    function automatic int exp_lat(input logic [N-1:0] m);
        int lat = 1;
        for (int i = 0; i < N; i++) lat += m[i] ? 1 : dly[i] + 2;
        return lat;
    endfunction

    function automatic int exp_clr(input logic [N-1:0] m);
        int code = 0;
        for (int i = 0; i < N; i++) if (!m[i]) code = (code << 3) | (i + 1);
        return code;
    endfunction

    function automatic int exp_bank(input logic [N-1:0] m);
        int code = 0;
        int k = 0;
        for (int i = 0; i < N; i++) if (!m[i]) begin
            code = (code << 1) | (k % 2);
            k++;
        end
        return code;
    endfunction

    function automatic logic exp_res(input logic [N-1:0] m);
        int k = 0;
        for (int i = 0; i < N; i++) if (!m[i]) k++;
        return logic'(k % 2);
    endfunction

    function automatic logic [N-1:0] sel_of(input logic [1:0] idx);
        logic [N-1:0] s = '0;
        if (int'(idx) < N) s[idx] = 1'b1;
        return s;
    endfunction

    // ---------------- cycle driver + unit model ----------------
    task automatic tick();
        int idx;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (stage_clr != '0) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (stage_clr[i]) idx = i;
            clr_code  = (clr_code << 3) | (idx + 1);
            bank_code = (bank_code << 1) | int'(rd_bank);
            if (first_clr_cyc < 0) first_clr_cyc = cyc;
            if (stage_clr != sel_of(stage_idx)) onehot_bad++;
        end
        if (stage_start != '0 && stage_start != sel_of(stage_idx)) onehot_bad++;
        if (job_done) begin
            done_cnt++;
            done_cyc = cyc;
            res_obs  = res_bank;
            cnt_obs  = job_count;
        end
        if (unit_auto) begin
            for (int i = 0; i < N; i++) begin
                if (stage_clr[i]) begin
                    stage_done[i] = 1'b0;
                    scnt[i] = 0;
                end
                if (stage_start[i]) begin
                    scnt[i]++;
                    if (scnt[i] == dly[i]) stage_done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic run_job(input logic [N-1:0] m, input bit keep, input int limit,
                           output int waited, output bit ok);
        job_valid = 1'b1;
        mask_drv  = m;
        waited    = 0;
        while (!job_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!job_ready) begin
            job_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        cyc = 0;
        clr_code = 0;
        bank_code = 0;
        done_cnt = 0;
        done_cyc = -1;
        first_clr_cyc = -1;
        tick();
        if (!keep) job_valid = 1'b0;
        while (done_cnt == 0 && !error && cyc < limit) tick();
        ok = (done_cnt == 1);
    endtask

    function automatic logic [23:0] out_vec();
        return {job_ready, job_done, res_bank, busy, stage_idx, stage_clr, stage_start,
                rd_bank, job_count, error, err_stage};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int w;
        bit ok;
        rst = 1'b0; job_valid = 1'b0; err_clr = 1'b0; stage_done = '0; mask_drv = '0;
        unit_auto = 1'b1;
        for (int i = 0; i < N; i++) begin dly[i] = 50; scnt[i] = 0; end
        repeat (3) @(negedge clk);
        compared++;
        if (out_vec() !== 24'h800000) begin
            mismatched++;
            $display("FAIL reset_state: got %h expected %h", out_vec(), 24'h800000);
        end
        rst = 1'b1;
        tick();
        // Start a job and assert reset while stage 0 holds start.
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        repeat (4) tick();
        compared++;
        if (stage_start !== 3'b001 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_pre_start: got start=%b busy=%b expected start=001 busy=1",
                     stage_start, busy);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (out_vec() !== 24'h800000) begin
            mismatched++;
            $display("FAIL reset_mid_start: got %h expected %h", out_vec(), 24'h800000);
        end
        @(negedge clk);
        stage_done = '0;
        for (int i = 0; i < N; i++) begin dly[i] = 1; scnt[i] = 0; end
        exp_cnt = 0;
        rst = 1'b1;
        run_job('0, 1'b0, 500, w, ok);
        exp_cnt++;
        compared++;
        if (!ok || first_clr_cyc != 1 || clr_code != exp_clr('0) || done_cyc != exp_lat('0)) begin
            mismatched++;
            $display("FAIL reset_restart: got ok=%0d clr_cyc=%0d clr=%0h done=%0d expected 1/1/%0h/%0d",
                     ok, first_clr_cyc, clr_code, done_cyc, exp_clr('0), exp_lat('0));
        end
        compared++;
        if (cnt_obs !== 8'(exp_cnt)) begin
            mismatched++;
            $display("FAIL reset_count: got %0d expected %0d", cnt_obs, exp_cnt);
        end
    endtask

    task automatic test_nominal();
        int w;
        bit ok;
        for (int i = 0; i < N; i++) dly[i] = 70;
        onehot_bad = 0;
        run_job('0, 1'b0, 2000, w, ok);
        exp_cnt++;
        compared++;
        if (clr_code != exp_clr('0) || bank_code != exp_bank('0)) begin
            mismatched++;
            $display("FAIL nominal_order: got clr=%0h bank=%0h expected clr=%0h bank=%0h",
                     clr_code, bank_code, exp_clr('0), exp_bank('0));
        end
        compared++;
        if (done_cnt != 1 || done_cyc != exp_lat('0)) begin
            mismatched++;
            $display("FAIL nominal_done: got cnt=%0d cyc=%0d expected 1 %0d",
                     done_cnt, done_cyc, exp_lat('0));
        end
        compared++;
        if (res_obs !== exp_res('0) || cnt_obs !== 8'(exp_cnt)) begin
            mismatched++;
            $display("FAIL nominal_result: got res=%b cnt=%0d expected res=%b cnt=%0d",
                     res_obs, cnt_obs, exp_res('0), exp_cnt);
        end
        compared++;
        if (onehot_bad != 0) begin
            mismatched++;
            $display("FAIL nominal_onehot: got %0d violations expected 0", onehot_bad);
        end
        // Job stays idle afterwards: done pulse must not repeat.
        repeat (3) tick();
        compared++;
        if (done_cnt != 1 || job_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL nominal_idle: got cnt=%0d ready=%b busy=%b expected 1 1 0",
                     done_cnt, job_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        bit ok;
        for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 5));
        run_job('0, 1'b1, 500, w, ok);
        exp_cnt++;
        compared++;
        if (!ok || done_cyc != exp_lat('0) || res_obs !== exp_res('0)) begin
            mismatched++;
            $display("FAIL b2b_first: got ok=%0d cyc=%0d res=%b expected 1 %0d %b",
                     ok, done_cyc, res_obs, exp_lat('0), exp_res('0));
        end
        run_job('0, 1'b0, 500, w, ok);
        exp_cnt++;
        compared++;
        if (w != 1) begin
            mismatched++;
            $display("FAIL b2b_gap: got %0d cycles after job_done expected 1", w);
        end
        compared++;
        if (!ok || bank_code != exp_bank('0) || cnt_obs !== 8'(exp_cnt)) begin
            mismatched++;
            $display("FAIL b2b_second: got ok=%0d bank=%0h cnt=%0d expected 1 %0h %0d",
                     ok, bank_code, cnt_obs, exp_bank('0), exp_cnt);
        end
    endtask

    task automatic test_timeout();
        int w;
        bit ok;
        dly[0] = 1; dly[1] = 0; dly[2] = 1;
        run_job('0, 1'b0, 9000, w, ok);
        compared++;
        if (ok || scnt[1] != TO || error !== 1'b1 || err_stage !== 2'd1) begin
            mismatched++;
            $display("FAIL timeout_hit: got starts=%0d err=%b stage=%0d expected %0d 1 1",
                     scnt[1], error, err_stage, TO);
        end
        compared++;
        if (job_ready !== 1'b0 || busy !== 1'b0 || stage_start !== '0 || stage_clr !== '0) begin
            mismatched++;
            $display("FAIL timeout_outputs: got ready=%b busy=%b start=%b clr=%b expected 0 0 0 0",
                     job_ready, busy, stage_start, stage_clr);
        end
        job_valid = 1'b1;
        repeat (3) tick();
        job_valid = 1'b0;
        compared++;
        if (error !== 1'b1 || busy !== 1'b0 || job_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_sticky: got err=%b busy=%b ready=%b expected 1 0 0",
                     error, busy, job_ready);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        compared++;
        if (error !== 1'b0 || err_stage !== 2'd0 || job_ready !== 1'b1 || job_count !== 8'(exp_cnt)) begin
            mismatched++;
            $display("FAIL timeout_clear: got err=%b stage=%0d ready=%b cnt=%0d expected 0 0 1 %0d",
                     error, err_stage, job_ready, job_count, exp_cnt);
        end
        // Done rising in the final allowed START cycle must still win.
        dly[0] = 1; dly[1] = TO; dly[2] = 1;
        run_job('0, 1'b0, 9000, w, ok);
        exp_cnt++;
        compared++;
        if (!ok || error !== 1'b0 || done_cyc != exp_lat('0)) begin
            mismatched++;
            $display("FAIL timeout_edge_wins: got ok=%0d err=%b cyc=%0d expected 1 0 %0d",
                     ok, error, done_cyc, exp_lat('0));
        end
    endtask

    task automatic test_stray_done();
        int guard;
        unit_auto = 1'b0;
        stage_done = 3'b001;
        job_valid = 1'b1;
        guard = 0;
        while (!job_ready && guard < 50) begin tick(); guard++; end
        tick();
        job_valid = 1'b0;
        tick();
        tick();
        stage_done[2] = 1'b1;
        tick();
        stage_done[2] = 1'b0;
        repeat (4) tick();
        compared++;
        if (stage_start !== 3'b001 || stage_idx !== 2'd0) begin
            mismatched++;
            $display("FAIL stray_ignored: got start=%b idx=%0d expected 001 0", stage_start, stage_idx);
        end
        stage_done[0] = 1'b0;
        tick();
        compared++;
        if (stage_start !== 3'b001) begin
            mismatched++;
            $display("FAIL stray_fall: got start=%b expected 001", stage_start);
        end
        stage_done[0] = 1'b1;
        tick();
        compared++;
        if (stage_start !== 3'b000 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL stray_fresh_rise: got start=%b busy=%b expected 000 1", stage_start, busy);
        end
        tick();
        compared++;
        if (stage_clr !== 3'b010 || rd_bank !== 1'b1) begin
            mismatched++;
            $display("FAIL stray_next_stage: got clr=%b bank=%b expected 010 1", stage_clr, rd_bank);
        end
        for (int i = 0; i < N; i++) begin dly[i] = 1; scnt[i] = 0; end
        unit_auto = 1'b1;
        done_cnt = 0;
        guard = 0;
        while (done_cnt == 0 && guard < 100) begin tick(); guard++; end
        exp_cnt++;
        compared++;
        if (done_cnt != 1 || res_obs !== exp_res('0) || cnt_obs !== 8'(exp_cnt)) begin
            mismatched++;
            $display("FAIL stray_complete: got done=%0d res=%b cnt=%0d expected 1 %b %0d",
                     done_cnt, res_obs, cnt_obs, exp_res('0), exp_cnt);
        end
    endtask

`ifdef SEQ_BYPASS_EN
    task automatic test_bypass();
        int w;
        bit ok;
        for (int i = 0; i < N; i++) dly[i] = 1;
        run_job(3'b010, 1'b0, 500, w, ok);
        exp_cnt++;
        compared++;
        if (!ok || clr_code != exp_clr(3'b010) || bank_code != exp_bank(3'b010) ||
            res_obs !== exp_res(3'b010) || done_cyc != exp_lat(3'b010)) begin
            mismatched++;
            $display("FAIL bypass_010: got clr=%0h bank=%0h res=%b cyc=%0d expected %0h %0h %b %0d",
                     clr_code, bank_code, res_obs, done_cyc, exp_clr(3'b010), exp_bank(3'b010),
                     exp_res(3'b010), exp_lat(3'b010));
        end
        run_job(3'b111, 1'b0, 500, w, ok);
        exp_cnt++;
        compared++;
        if (!ok || clr_code != 0 || res_obs !== 1'b0 || done_cyc != N + 1) begin
            mismatched++;
            $display("FAIL bypass_111: got clr=%0h res=%b cyc=%0d expected 0 0 %0d",
                     clr_code, res_obs, done_cyc, N + 1);
        end
    endtask
`endif

    task automatic test_random();
        int w;
        bit ok;
        int bad = 0;
        logic [N-1:0] m;
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 12));
`ifdef SEQ_BYPASS_EN
            m = N'($urandom_range(0, (1 << N) - 1));
`else
            m = '0;
`endif
            onehot_bad = 0;
            run_job(m, 1'b0, 500, w, ok);
            exp_cnt++;
            if (!ok || done_cyc != exp_lat(m) || clr_code != exp_clr(m) ||
                bank_code != exp_bank(m) || res_obs !== exp_res(m) ||
                cnt_obs !== 8'(exp_cnt) || onehot_bad != 0) begin
                bad++;
                $display("FAIL random_job%0d: got cyc=%0d clr=%0h bank=%0h res=%b cnt=%0d expected %0d %0h %0h %b %0d",
                         j, done_cyc, clr_code, bank_code, res_obs, cnt_obs,
                         exp_lat(m), exp_clr(m), exp_bank(m), exp_res(m), exp_cnt);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL random_jobs: got %0d bad jobs expected 0", bad);
        end
    endtask

    task automatic test_count_wrap();
        int w;
        bit ok;
        int bad = 0;
        for (int i = 0; i < N; i++) dly[i] = 1;
        while ((exp_cnt % 256) != 255) begin
            run_job('0, 1'b0, 200, w, ok);
            exp_cnt++;
            if (!ok || cnt_obs !== 8'(exp_cnt)) bad++;
        end
        compared++;
        if (bad != 0 || job_count !== 8'd255) begin
            mismatched++;
            $display("FAIL count_climb: got %0d bad, count=%0d expected 0 bad, 255", bad, job_count);
        end
        run_job('0, 1'b0, 200, w, ok);
        exp_cnt++;
        compared++;
        if (cnt_obs !== 8'd0) begin
            mismatched++;
            $display("FAIL count_wrap: got %0d expected 0", cnt_obs);
        end
        run_job('0, 1'b0, 200, w, ok);
        exp_cnt++;
        compared++;
        if (cnt_obs !== 8'd1) begin
            mismatched++;
            $display("FAIL count_after_wrap: got %0d expected 1", cnt_obs);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_timeout();
        test_stray_done();
`ifdef SEQ_BYPASS_EN
        test_bypass();
`endif
        test_random();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
